ssram_arb: RTL
==============

Name: ssram_arb

Overview:
Two-port arbiter and burst sequencer for the board's single 32-bit pipelined SSRAM. Port 0 carries the console's 64-bit main-memory traffic; port 1 carries loader/debug traffic. The block grants one 64-bit read or write at a time and runs it as a two-beat SSRAM burst: upper dword at the base address, lower dword at base+4. It drives the split DQ bus; top level builds the tristate.

Parameters:
FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin between ports
TURN_CYC, 1, idle bus-turnaround cycles after every burst (1..3)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
xresetl  in  1  asynchronous active-low reset
req0, req1  in  1  request; hold until ack
we0, we1  in  1  1 = write, 0 = read
addr0, addr1  in  21  byte address; [2:0] ignored
be0, be1  in  8  byte enables, active high; [7:4] = upper dword
wdata0, wdata1  in  64  write data; [63:32] = upper dword
ack0, ack1  out  1  one-cycle pulse: request accepted and latched
rvalid0, rvalid1  out  1  one-cycle pulse: rdata valid
rdata0, rdata1  out  64  read data; held until next read on that port
ss_addr  out  21  SSRAM address, [2:0] = 0
ss_ce1_n, ss_oe_n, ss_bwe_n, ss_adsc_n, ss_adsp_n, ss_adv_n  out  1  SSRAM controls
ss_be_n  out  4  SSRAM byte enables, active low
ss_dq_o  out  32  write data
ss_dq_oe  out  1  drive enable for ss_dq_o
ss_dq_i  in  32  read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all *_n outputs 1; ack, rvalid, ss_dq_oe and busy 0; rdata, ss_addr and ss_dq_o 0; last-grant register = port 1, so port 0 wins first.
- Reset is asynchronous. Asserting xresetl mid-burst aborts to IDLE immediately. The aborted request gets no ack/rvalid if not yet acked; if already acked, it gets no rvalid.
- Arbitration happens only in IDLE.
  - FIXED_PRIO=1: port 0 wins when both request.
  - FIXED_PRIO=0: the port not granted last wins; a lone requester always wins.
- On the grant edge: latch we, addr[20:3], be and wdata; set ss_addr = {addr[20:3],3'b000}; enter RD_A or WR_A.
- ack of the granted port pulses in RD_A/WR_A. The requester must drop or change req on the cycle after ack. A req still high in the next IDLE is a new request.
- Read sequence:
  - RD_A: ce1_n=0, adsc_n=0.
  - RD_V: adv_n=0, oe_n=0.
  - RD_0: oe_n=0; capture ss_dq_i into rdata[63:32] at the closing edge.
  - RD_1: oe_n=0; capture into rdata[31:0].
  - TURN: rvalid of the granted port pulses in the first TURN cycle.
- Write sequence:
  - WR_A: ce1_n=0, adsp_n=0.
  - WR_0: bwe_n=0, be_n=~be[7:4], dq_o=wdata[63:32], dq_oe=1.
  - WR_1: bwe_n=0, adv_n=0, be_n=~be[3:0], dq_o=wdata[31:0], dq_oe=1.
  - TURN.
- TURN: all controls inactive, dq_oe=0, lasts TURN_CYC cycles, then IDLE.
- Minimum request spacing: read 5+TURN_CYC cycles, write 4+TURN_CYC cycles (IDLE cycle included).
- ss_be_n is 4'b1111 outside WR_0/WR_1. ss_dq_oe is never high in RD_* or TURN, so there is no contention.
- be=0 write: full sequence runs with be_n=1111 (no bytes written); ack is still issued.
- Address wrap: addr 0x1FFFF8 second beat goes to 0x1FFFFC; no carry beyond bit 20.
- Simultaneous req0/req1 with different we: arbitration ignores we.
- rvalid and ack never pulse for the non-granted port.
- Outputs ss_* are registered (driven from state/latched registers).

Decomposition:
- defs.v: state encodings `SA_IDLE, `SA_RD_A, `SA_RD_V, `SA_RD_0, `SA_RD_1, `SA_WR_A, `SA_WR_0, `SA_WR_1, `SA_TURN.
- One sub-module, ssram_rr_arb: 2-way arbiter holding the last-grant flag, with FIXED_PRIO. Inputs req0/req1 and advance strobe; outputs one-hot grant.

Test Plan:
- Reset, then req0 read at 0x000100 with SSRAM model returning 0xAAAA5555 then 0x12345678 -> ack0 in cycle 1 after grant; ss_addr=0x000100; rvalid0 with rdata0=0xAAAA5555_12345678; ack1/rvalid1 never pulse.
- req1 write addr 0x00FF0F, be=8'hF0, wdata=0x11223344_55667788 -> ss_addr=0x00FF08; WR_0 be_n=0000 dq=0x11223344; WR_1 be_n=1111 dq=0x55667788; model memory upper dword written only.
- req0 and req1 held high continuously, FIXED_PRIO=0 -> grants alternate 0,1,0,1; with FIXED_PRIO=1 -> port 1 is never granted.
- Back-to-back read then write, TURN_CYC=2 -> two cycles of dq_oe=0 with all controls high between RD_1 and WR_A; no cycle has dq_oe=1 together with oe_n=0.
- xresetl low during RD_0 -> all *_n outputs 1 asynchronously, no rvalid; after release, req0 read completes normally.
- Write at 0x1FFFF8 -> second beat lands at 0x1FFFFC and nothing is written at 0x000000.

Source files
------------

// File: rtl/ssram_arb_pkg.sv
// ssram_arb_pkg: burst sequencer state encoding and SSRAM control decode.
package ssram_arb_pkg;
  typedef enum logic [3:0] {SA_IDLE, SA_RD_A, SA_RD_V, SA_RD_0, SA_RD_1, SA_WR_A, SA_WR_0, SA_WR_1, SA_TURN} sa_state_t;
  typedef struct packed {
    logic ce1_n;
    logic oe_n;
    logic bwe_n;
    logic adsc_n;
    logic adsp_n;
    logic adv_n;
  } ss_ctl_t;
  function automatic ss_ctl_t ctl_of(sa_state_t s);
    return '{ce1_n:  !(s inside {SA_RD_A, SA_WR_A}),
             oe_n:   !(s inside {SA_RD_V, SA_RD_0, SA_RD_1}),
             bwe_n:  !(s inside {SA_WR_0, SA_WR_1}),
             adsc_n: s != SA_RD_A,
             adsp_n: s != SA_WR_A,
             adv_n:  !(s inside {SA_RD_V, SA_WR_1})};
  endfunction
endpackage

// File: rtl/ssram_arb_if.sv
// ssram_arb_if: two requester ports plus the split-DQ SSRAM bus.
interface ssram_arb_if;
  logic req0, req1, we0, we1, ack0, ack1, rvalid0, rvalid1;
  logic [20:0] addr0, addr1, ss_addr;
  logic [7:0] be0, be1;
  logic [63:0] wdata0, wdata1, rdata0, rdata1;
  logic ss_ce1_n, ss_oe_n, ss_bwe_n, ss_adsc_n, ss_adsp_n, ss_adv_n, ss_dq_oe;
  logic [3:0] ss_be_n;
  logic [31:0] ss_dq_o, ss_dq_i;
  modport slave (
    input req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, ss_dq_i,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, ss_addr,
    output ss_ce1_n, ss_oe_n, ss_bwe_n, ss_adsc_n, ss_adsp_n, ss_adv_n, ss_be_n, ss_dq_o, ss_dq_oe
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, ss_dq_i,
    input ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, ss_addr,
    input ss_ce1_n, ss_oe_n, ss_bwe_n, ss_adsc_n, ss_adsp_n, ss_adv_n, ss_be_n, ss_dq_o, ss_dq_oe
  );
endinterface

// File: rtl/ssram_rr_arb.sv
// ssram_rr_arb: two-way grant; last-grant flag gives round-robin unless FIXED_PRIO.
module ssram_rr_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       sys_clk,
  input  logic       xresetl,
  input  logic       req0,
  input  logic       req1,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic last;
  always_comb begin
    gnt[0] = req0 && (!req1 || FIXED_PRIO || last);
    gnt[1] = req1 && !gnt[0];
  end
  always_ff @(posedge sys_clk or negedge xresetl)
    if (!xresetl) last <= 1'b1;
    else if (adv && |gnt) last <= gnt[1];
endmodule

// File: rtl/ssram_arb.sv
// ssram_arb: grants one 64-bit access at a time and runs it as a two-beat
// pipelined SSRAM burst (upper dword first); all SSRAM pins registered.
module ssram_arb
  import ssram_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TURN_CYC   = 1
) (
  input  logic        sys_clk,
  input  logic        xresetl,
  ssram_arb_if.slave  bus,
  output logic        busy
);
  sa_state_t state, nx;
  logic [1:0] gnt, tcnt;
  logic gp;
  logic [7:0] cbe;
  logic [63:0] cwd;
  ssram_rr_arb #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .sys_clk, .xresetl, .req0(bus.req0), .req1(bus.req1), .adv(state == SA_IDLE), .gnt
  );
  always_comb begin
    nx = SA_IDLE;
    case (state)
      SA_IDLE: nx = !(|gnt) ? SA_IDLE : (gnt[0] ? bus.we0 : bus.we1) ? SA_WR_A : SA_RD_A;
      SA_RD_A: nx = SA_RD_V;
      SA_RD_V: nx = SA_RD_0;
      SA_RD_0: nx = SA_RD_1;
      SA_WR_A: nx = SA_WR_0;
      SA_WR_0: nx = SA_WR_1;
      SA_RD_1, SA_WR_1: nx = SA_TURN;
      SA_TURN: nx = tcnt == 2'(TURN_CYC - 1) ? SA_IDLE : SA_TURN;
      default: nx = SA_IDLE;
    endcase
  end
  // Pin values are decoded from the next state so they appear exactly in that state.
  always_ff @(posedge sys_clk or negedge xresetl)
    if (!xresetl) begin
      state <= SA_IDLE;
      tcnt <= '0;
      gp <= 1'b0;
      cbe <= '0;
      cwd <= '0;
      busy <= 1'b0;
      {bus.ss_ce1_n, bus.ss_oe_n, bus.ss_bwe_n, bus.ss_adsc_n, bus.ss_adsp_n, bus.ss_adv_n} <= '1;
      bus.ss_be_n <= '1;
      bus.ss_dq_o <= '0;
      bus.ss_dq_oe <= 1'b0;
      bus.ss_addr <= '0;
      {bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1} <= '0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
    end else begin
      state <= nx;
      {bus.ss_ce1_n, bus.ss_oe_n, bus.ss_bwe_n, bus.ss_adsc_n, bus.ss_adsp_n, bus.ss_adv_n} <= ctl_of(nx);
      bus.ss_be_n <= nx == SA_WR_0 ? ~cbe[7:4] : nx == SA_WR_1 ? ~cbe[3:0] : 4'hF;
      bus.ss_dq_oe <= nx inside {SA_WR_0, SA_WR_1};
      if (nx inside {SA_WR_0, SA_WR_1}) bus.ss_dq_o <= nx == SA_WR_0 ? cwd[63:32] : cwd[31:0];
      busy <= nx != SA_IDLE;
      tcnt <= state == SA_TURN ? tcnt + 2'd1 : 2'd0;
      bus.ack0 <= state == SA_IDLE && gnt[0];
      bus.ack1 <= state == SA_IDLE && gnt[1];
      bus.rvalid0 <= state == SA_RD_1 && !gp;
      bus.rvalid1 <= state == SA_RD_1 && gp;
      if (state == SA_IDLE && |gnt) begin
        gp <= gnt[1];
        cbe <= gnt[1] ? bus.be1 : bus.be0;
        cwd <= gnt[1] ? bus.wdata1 : bus.wdata0;
        bus.ss_addr <= (gnt[1] ? bus.addr1 : bus.addr0) & ~21'h7;
      end
      if (state == SA_RD_0 && !gp) bus.rdata0[63:32] <= bus.ss_dq_i;
      if (state == SA_RD_1 && !gp) bus.rdata0[31:0] <= bus.ss_dq_i;
      if (state == SA_RD_0 && gp) bus.rdata1[63:32] <= bus.ss_dq_i;
      if (state == SA_RD_1 && gp) bus.rdata1[31:0] <= bus.ss_dq_i;
    end
endmodule
